// File: rtl/load_unit_pkg.sv
// Shared types and helpers for the load path: load op encoding, FSM states,
// alignment check and byte-lane extraction/extension.
package load_unit_pkg;

   localparam int unsigned LoadOpWidth = 3;

   typedef enum logic [LoadOpWidth-1:0] {
      LoadLb,
      LoadLh,
      LoadLw,
      LoadLbu,
      LoadLhu,
      LoadIll
   } load_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StReq0,
      StReq1,
      StDone
   } load_state_e;

   function automatic logic is_misaligned(load_op_e op, logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (op)
         LoadLh, LoadLhu: mis = (off == 2'd3);
         LoadLw:          mis = (off != 2'd0);
         default:         mis = 1'b0;
      endcase
      return mis;
   endfunction

   // w1 is the following word for split loads, zero otherwise.
   function automatic logic [31:0] load_extract(load_op_e op, logic [1:0] off,
                                                logic [31:0] w1, logic [31:0] w0);
      logic [31:0] x;
      logic [31:0] res;
      x = 32'({w1, w0} >> {off, 3'b000});
      case (op)
         LoadLb:  res = {{24{x[7]}}, x[7:0]};
         LoadLbu: res = {24'h0, x[7:0]};
         LoadLh:  res = {{16{x[15]}}, x[15:0]};
         LoadLhu: res = {16'h0, x[15:0]};
         default: res = x;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/load_unit_if.sv
// Native memory bus (valid/ready) as seen by the load unit.
interface load_unit_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [3:0]  mem_wstrb;

   modport master (
      output mem_valid, mem_addr, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/load_unit_decoder.sv
// Combinational funct3 to load op decode; mirror of the store decoder.
module load_unit_decoder
   import load_unit_pkg::*;
(
   input  logic [2:0] funct3_i,
   output load_op_e   op_o
);

   always_comb begin
      op_o = LoadIll;
      case (funct3_i)
         3'b000:  op_o = LoadLb;
         3'b001:  op_o = LoadLh;
         3'b010:  op_o = LoadLw;
         3'b100:  op_o = LoadLbu;
         3'b101:  op_o = LoadLhu;
         default: op_o = LoadIll;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Multicycle load unit: issues one or two word reads, then extracts and extends
// the addressed byte/halfword/word and pulses done for one cycle.
module load_unit
   import load_unit_pkg::*;
#(
   parameter bit          SPLIT_MISALIGNED = 1'b1,
   parameter logic [31:0] RESET_RDATA      = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rd_data_o,
   output logic        misaligned_o,
   output logic        illegal_o,
   load_unit_if.master mem
);

   load_op_e    dec_op;
   logic        start_mis;

   load_state_e state_q;
   load_op_e    op_q;
   logic [1:0]  off_q;
   logic        split_q;
   logic [31:0] w0_q;
   logic [31:0] mem_addr_q;
   logic [31:0] rd_data_q;
   logic        busy_q;
   logic        done_q;
   logic        mis_q;
   logic        ill_q;
   logic        valid_q;

   load_unit_decoder u_decoder (
      .funct3_i (funct3_i),
      .op_o     (dec_op)
   );

   assign start_mis = is_misaligned(dec_op, addr_i[1:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         op_q       <= LoadLb;
         off_q      <= 2'd0;
         split_q    <= 1'b0;
         w0_q       <= 32'h0;
         mem_addr_q <= 32'h0;
         rd_data_q  <= RESET_RDATA;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mis_q      <= 1'b0;
         ill_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  op_q    <= dec_op;
                  off_q   <= addr_i[1:0];
                  split_q <= start_mis;
                  if (dec_op == LoadIll) begin
                     state_q   <= StDone;
                     done_q    <= 1'b1;
                     ill_q     <= 1'b1;
                     rd_data_q <= RESET_RDATA;
                  end else if (start_mis && !SPLIT_MISALIGNED) begin
                     state_q   <= StDone;
                     done_q    <= 1'b1;
                     mis_q     <= 1'b1;
                     rd_data_q <= RESET_RDATA;
                  end else begin
                     state_q    <= StReq0;
                     busy_q     <= 1'b1;
                     valid_q    <= 1'b1;
                     mem_addr_q <= {addr_i[31:2], 2'b00};
                  end
               end
            end
            StReq0: begin
               if (mem.mem_ready) begin
                  valid_q <= 1'b0;
                  if (split_q) begin
                     w0_q       <= mem.mem_rdata;
                     mem_addr_q <= mem_addr_q + 32'd4;
                     state_q    <= StReq1;
                  end else begin
                     rd_data_q <= load_extract(op_q, off_q, 32'h0, mem.mem_rdata);
                     state_q   <= StDone;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                  end
               end
            end
            StReq1: begin
               // First cycle in this state is the mandatory idle gap on the bus.
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (mem.mem_ready) begin
                  valid_q   <= 1'b0;
                  rd_data_q <= load_extract(op_q, off_q, mem.mem_rdata, w0_q);
                  state_q   <= StDone;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  mis_q     <= 1'b1;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               mis_q   <= 1'b0;
               ill_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign rd_data_o     = rd_data_q;
   assign misaligned_o  = mis_q;
   assign illegal_o     = ill_q;
   assign mem.mem_valid = valid_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wstrb = 4'b0000;

endmodule
